// File: rtl/pipelined_shifter_if.sv
// Handshake bundle for the pipelined shifter: operation request on the input side,
// result with its tag on the output side.
interface pipelined_shifter_if #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned SHAMT_W = 32,
   parameter int unsigned TAG_W   = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  data_in;
   logic [SHAMT_W-1:0] shift_amount;
   logic [1:0]         mode;
   logic [TAG_W-1:0]   tag_in;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  data_out;
   logic [TAG_W-1:0]   tag_out;

   modport master (
      output in_valid, data_in, shift_amount, mode, tag_in, out_ready,
      input  in_ready, out_valid, data_out, tag_out
   );

   modport slave (
      input  in_valid, data_in, shift_amount, mode, tag_in, out_ready,
      output in_ready, out_valid, data_out, tag_out
   );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: one register stage per amount bit, SLL/SRL/SRA/ROR,
// tag sideband, whole-pipe stall on output backpressure.
module pipelined_shifter #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned SHAMT_W    = 32,
   parameter int unsigned MASK_SHAMT = 1,
   parameter int unsigned TAG_W      = 4
) (
   input logic                clk,
   input logic                rst,
   pipelined_shifter_if.slave bus
);
   localparam int unsigned L = $clog2(DATA_W);

   typedef logic [DATA_W-1:0] data_t;
   typedef enum logic [1:0] {
      ModeSll = 2'b00,
      ModeSrl = 2'b01,
      ModeRor = 2'b10,
      ModeSra = 2'b11
   } mode_e;

   logic stall;

   function automatic data_t step(data_t x, mode_e m, logic sg, int unsigned sh);
      data_t ones;
      data_t r;
      ones = '1;
      unique case (m)
         ModeSll: r = x << sh;
         ModeSrl: r = x >> sh;
         ModeSra: r = sg ? ((x >> sh) | ~(ones >> sh)) : (x >> sh);
         ModeRor: r = (x >> sh) | (x << (DATA_W - sh));
      endcase
      return r;
   endfunction

   for (genvar k = 0; k < L; k++) begin : g_stage
      logic             v_in, v_q;
      data_t            d_in, d_q, d_nxt;
      logic [L-1-k:0]   a_in;
      mode_e            m_in, m_q;
      logic             sg_in, sg_q;
      logic             st_in, st_q;
      logic [TAG_W-1:0] tg_in, tg_q;

      if (k == 0) begin : g_src
         assign v_in  = bus.in_valid;
         assign d_in  = bus.data_in;
         assign a_in  = bus.shift_amount[L-1:0];
         assign m_in  = mode_e'(bus.mode);
         assign sg_in = bus.data_in[DATA_W-1];
         assign tg_in = bus.tag_in;
         // Amount >= DATA_W iff any bit above the low L bits is set; ROR never saturates.
         assign st_in = (MASK_SHAMT == 0) && (mode_e'(bus.mode) != ModeRor) &&
                        (|(bus.shift_amount >> L));
      end else begin : g_src
         assign v_in  = g_stage[k-1].v_q;
         assign d_in  = g_stage[k-1].d_q;
         assign a_in  = g_stage[k-1].g_amt.a_q;
         assign m_in  = g_stage[k-1].m_q;
         assign sg_in = g_stage[k-1].sg_q;
         assign st_in = g_stage[k-1].st_q;
         assign tg_in = g_stage[k-1].tg_q;
      end

      // a_in[0] is amount bit k; remaining bits ride down to later stages.
      assign d_nxt = a_in[0] ? step(d_in, m_in, sg_in, 1 << k) : d_in;

      if (k < L - 1) begin : g_amt
         logic [L-2-k:0] a_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
            end else if (!stall && v_in) begin
               a_q <= a_in[L-1-k:1];
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q  <= 1'b0;
            d_q  <= '0;
            m_q  <= ModeSll;
            sg_q <= 1'b0;
            st_q <= 1'b0;
            tg_q <= '0;
         end else if (!stall) begin
            v_q <= v_in;
            if (v_in) begin
               d_q  <= d_nxt;
               m_q  <= m_in;
               sg_q <= sg_in;
               st_q <= st_in;
               tg_q <= tg_in;
            end
         end
      end
   end

   assign stall         = g_stage[L-1].v_q && !bus.out_ready;
   assign bus.in_ready  = !rst && !stall;
   assign bus.out_valid = g_stage[L-1].v_q;
   assign bus.tag_out   = g_stage[L-1].tg_q;
   assign bus.data_out  = !g_stage[L-1].st_q ? g_stage[L-1].d_q :
                          (g_stage[L-1].m_q == ModeSra && g_stage[L-1].sg_q) ? '1 : '0;
endmodule

// File: tb/tb_pipelined_shifter.sv
// Randomised scoreboard bench for pipelined_shifter, one masked and one saturating
// instance driven in lockstep.
module tb_pipelined_shifter;
   localparam int DW = 32;
   localparam int SW = 32;
   localparam int TW = 4;
   localparam int LAT = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipelined_shifter_if #(.DATA_W(DW), .SHAMT_W(SW), .TAG_W(TW)) bm ();
   pipelined_shifter_if #(.DATA_W(DW), .SHAMT_W(SW), .TAG_W(TW)) bs ();

   pipelined_shifter #(.DATA_W(DW), .SHAMT_W(SW), .MASK_SHAMT(1), .TAG_W(TW)) dut_mask (
      .clk(clk), .rst(rst), .bus(bm)
   );
   pipelined_shifter #(.DATA_W(DW), .SHAMT_W(SW), .MASK_SHAMT(0), .TAG_W(TW)) dut_sat (
      .clk(clk), .rst(rst), .bus(bs)
   );

   typedef struct {
      logic [DW-1:0] dm;
      logic [DW-1:0] ds;
      logic [TW-1:0] tag;
      int            acc;
      int            snap;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   stalls = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain arithmetic on the effective amount.
   function automatic logic [DW-1:0] model(logic [DW-1:0] d, logic [SW-1:0] amt,
                                           logic [1:0] m, bit mask);
      int unsigned s;
      s = amt % DW;
      if (!mask && amt >= DW && m != 2'b10) return (m == 2'b11 && d[DW-1]) ? '1 : '0;
      case (m)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b11:   return $signed(d) >>> s;
         default: return (d >> s) | (d << (DW - s));
      endcase
   endfunction

   task automatic drive(input bit v, input logic [DW-1:0] d, input logic [SW-1:0] a,
                        input logic [1:0] m, input logic [TW-1:0] t, input bit r);
      @(posedge clk);
      #1;
      bm.in_valid = v; bm.data_in = d; bm.shift_amount = a; bm.mode = m;
      bm.tag_in = t;   bm.out_ready = r;
      bs.in_valid = v; bs.data_in = d; bs.shift_amount = a; bs.mode = m;
      bs.tag_in = t;   bs.out_ready = r;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] a,
                       input logic [1:0] m, input logic [TW-1:0] t);
      int n = 0;
      do begin
         drive(1'b1, d, a, m, t, 1'b1);
         @(negedge clk);
         n++;
      end while (!bm.in_ready && n < 20);
      check("send_accept", 64'(bm.in_ready), 64'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 60) begin
         drive(1'b0, DW'($urandom), SW'($urandom), 2'($urandom), TW'($urandom), 1'b1);
         @(negedge clk);
         n++;
      end
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Scoreboard: expected validity, data and ready derived from accepted ops and elapsed cycles.
   always @(negedge clk) begin : mon
      bit   ev;
      bit   st;
      exp_t e;
      cyc++;
      if (rst) begin
         check("in_ready_rst_mask", 64'(bm.in_ready), 64'd0);
         check("in_ready_rst_sat", 64'(bs.in_ready), 64'd0);
         sb.delete();
      end else begin
         ev = 1'b0;
         if (sb.size() > 0) ev = (cyc - sb[0].acc - (stalls - sb[0].snap)) >= LAT;
         check("out_valid_mask", 64'(bm.out_valid), 64'(ev));
         check("out_valid_sat", 64'(bs.out_valid), 64'(ev));
         if (ev) begin
            check("data_mask", 64'(bm.data_out), 64'(sb[0].dm));
            check("data_sat", 64'(bs.data_out), 64'(sb[0].ds));
            check("tag_mask", 64'(bm.tag_out), 64'(sb[0].tag));
            check("tag_sat", 64'(bs.tag_out), 64'(sb[0].tag));
         end
         st = ev && !bm.out_ready;
         check("in_ready_mask", 64'(bm.in_ready), 64'(!st));
         check("in_ready_sat", 64'(bs.in_ready), 64'(!st));
         if (ev && bm.out_ready) void'(sb.pop_front());
         if (st) stalls++;
         if (bm.in_valid && !st) begin
            e.dm   = model(bm.data_in, bm.shift_amount, bm.mode, 1'b1);
            e.ds   = model(bm.data_in, bm.shift_amount, bm.mode, 1'b0);
            e.tag  = bm.tag_in;
            e.acc  = cyc;
            e.snap = stalls;
            sb.push_back(e);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [DW-1:0] d_tab[12];
   logic [SW-1:0] a_tab[12];
   logic [1:0]    m_tab[12];
   logic [DW-1:0] bd[8];
   logic [SW-1:0] ba[8];
   logic [1:0]    bmd[8];

   initial begin : stim
      int idx;
      int j;
      int sel;
      logic [SW-1:0] amt;

      bm.in_valid = 1'b0; bm.data_in = '0; bm.shift_amount = '0; bm.mode = '0;
      bm.tag_in = '0;     bm.out_ready = 1'b1;
      bs.in_valid = 1'b0; bs.data_in = '0; bs.shift_amount = '0; bs.mode = '0;
      bs.tag_in = '0;     bs.out_ready = 1'b1;

      // Hand-computed values pin the reference model.
      check("pin_sra4", 64'(model(32'h8000_0000, 32'd4, 2'b11, 1'b1)), 64'hF800_0000);
      check("pin_srl4", 64'(model(32'h8000_0000, 32'd4, 2'b01, 1'b1)), 64'h0800_0000);
      check("pin_sll31", 64'(model(32'h0000_0001, 32'd31, 2'b00, 1'b1)), 64'h8000_0000);
      check("pin_sra_pos", 64'(model(32'h7FFF_FFF0, 32'd4, 2'b11, 1'b1)), 64'h07FF_FFFF);
      check("pin_ror1", 64'(model(32'h0000_0001, 32'd1, 2'b10, 1'b1)), 64'h8000_0000);
      check("pin_zero", 64'(model(32'hA5C3_0F96, 32'd0, 2'b11, 1'b0)), 64'hA5C3_0F96);
      check("pin_sra40_mask", 64'(model(32'h8000_0000, 32'd40, 2'b11, 1'b1)), 64'hFF80_0000);
      check("pin_sra40_sat", 64'(model(32'h8000_0000, 32'd40, 2'b11, 1'b0)), 64'hFFFF_FFFF);
      check("pin_srl40_sat", 64'(model(32'h8000_0000, 32'd40, 2'b01, 1'b0)), 64'h0000_0000);
      check("pin_ror40_sat", 64'(model(32'h8000_0000, 32'd40, 2'b10, 1'b0)), 64'h0080_0000);

      drive(1'b1, 32'hDEAD_BEEF, 32'd3, 2'b00, 4'd9, 1'b1);
      drive(1'b1, 32'hDEAD_BEEF, 32'd3, 2'b00, 4'd9, 1'b1);
      drive(1'b0, '0, '0, 2'b00, '0, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(bm.out_valid), 64'd0);
      check("rst_data_out", 64'(bm.data_out), 64'd0);
      check("rst_tag_out", 64'(bm.tag_out), 64'd0);
      check("rst_in_ready", 64'(bm.in_ready), 64'd1);
      check("rst_data_out_sat", 64'(bs.data_out), 64'd0);

      d_tab = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFF0, 32'h0000_0001,
                32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96,
                32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
      a_tab = '{32'd4, 32'd4, 32'd31, 32'd4, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0,
                32'd40, 32'd40, 32'd40};
      m_tab = '{2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10,
                2'b11, 2'b01, 2'b10};
      for (int i = 0; i < 12; i++) send(d_tab[i], a_tab[i], m_tab[i], TW'(i));
      drain();

      // Back-to-back stream at full flow.
      for (int i = 0; i < 8; i++) send(DW'($urandom), SW'($urandom_range(0, 45)),
                                       2'($urandom_range(0, 3)), TW'(i));
      drain();

      // Stream with a three-cycle output stall in the middle.
      for (int i = 0; i < 8; i++) begin
         bd[i] = DW'($urandom); ba[i] = SW'($urandom_range(0, 45));
         bmd[i] = 2'($urandom_range(0, 3));
      end
      idx = 0;
      j = 0;
      while (idx < 8 && j < 40) begin
         drive(1'b1, bd[idx], ba[idx], bmd[idx], TW'(idx), !(j >= 6 && j < 9));
         @(negedge clk);
         if (bm.in_ready) idx++;
         j++;
      end
      check("bp_stream_done", 64'(idx), 64'd8);
      drain();

      // Reset with three operations in flight.
      for (int i = 0; i < 3; i++) send(32'hF0F0_0000 + DW'(i), 32'd2, 2'b11, TW'(10 + i));
      drive(1'b1, 32'h1234_5678, 32'd8, 2'b10, 4'd15, 1'b1);
      rst = 1'b1;
      drive(1'b0, '0, '0, 2'b00, '0, 1'b1);
      rst = 1'b0;
      send(32'h0000_00FF, 32'd4, 2'b00, 4'd6);
      drain();

      // Random traffic with random backpressure; inputs change freely when not accepted.
      for (int i = 0; i < 600; i++) begin
         sel = int'($urandom_range(0, 3));
         case (sel)
            0:       amt = '0;
            1:       amt = SW'($urandom_range(1, 31));
            2:       amt = SW'($urandom_range(32, 70));
            default: amt = SW'($urandom);
         endcase
         drive($urandom_range(0, 9) < 7, DW'($urandom), amt, 2'($urandom_range(0, 3)),
               TW'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
